tx_segment_sequencer: RTL
=========================

TX_SEGMENT_SEQUENCER -- requirements
Module: tx_segment_sequencer

Interface
REQ-001 SHALL have parameter SEGMENT_NUMBER_MAX, default 150, max segments per picture.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 1080, payload bytes per segment.
REQ-003 SHALL have parameter GAP_CYCLES, default 12, idle cycles between segment transmissions.
REQ-004 SHALL have parameter MEM_LATENCY, default 3, read latency of the downstream memory control stage.
REQ-005 clk125MHz  in  1  sole clock; ethernet tx clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  permits starting a new picture.
REQ-008 redundancy  in  8  transmissions per segment; sampled at picture start.
REQ-009 segment_count  in  16  segments per picture; sampled at picture start.
REQ-010 mac_ready  in  1  frame builder can accept a new frame.
REQ-011 frame_start  out  1  one-cycle pulse; a segment transmission begins.
REQ-012 txid  out  8  current transmission index, 1..redundancy.
REQ-013 segment_num  out  16  current segment index.
REQ-014 count_for_bram  out  13  payload byte index, write side.
REQ-015 count_for_bram_b  out  13  payload byte index, read side.
REQ-016 count_for_bram_en  out  1  payload byte index valid.
REQ-017 data_user  out  1  high for the whole payload window.
REQ-018 byte_valid  out  1  data_user delayed MEM_LATENCY cycles; aligned with doutb.
REQ-019 picture_done  out  1  one-cycle pulse after the last transmission's gap.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states SHALL be IDLE, START, PAYLOAD, GAP.
REQ-022 IDLE->START SHALL occur when enable=1 and mac_ready=1; on this transition latch red_l=max(redundancy,1) and seg_l=min(max(segment_count,1),SEGMENT_NUMBER_MAX), and set txid=1, segment_num=0.
REQ-023 START SHALL last exactly one cycle with frame_start=1, then go to PAYLOAD.
REQ-024 PAYLOAD SHALL last exactly PAYLOAD_LEN cycles; count_for_bram=count_for_bram_b steps 0..PAYLOAD_LEN-1; count_for_bram_en=data_user=1.
REQ-025 PAYLOAD->GAP SHALL occur after index PAYLOAD_LEN-1; the index returns to 0.
REQ-026 GAP SHALL last GAP_CYCLES cycles; then advance txid and segment_num per REQ-027 to REQ-029.
REQ-027 If txid<red_l: increment txid, keep segment_num, go to START (waiting in GAP while mac_ready=0).
REQ-028 If txid=red_l and segment_num<seg_l-1: set txid=1, increment segment_num, go to START (same mac_ready wait).
REQ-029 If txid=red_l and segment_num=seg_l-1: pulse picture_done, go to IDLE.
REQ-030 If enable drops mid-picture, the current transmission SHALL complete through GAP, then return to IDLE without picture_done.
REQ-031 txid and segment_num SHALL be stable from START until GAP exit.
REQ-032 Counters SHALL never wrap; all compares are unsigned at their declared widths.
REQ-033 byte_valid SHALL equal data_user delayed exactly MEM_LATENCY cycles.
REQ-034 Changes to redundancy or segment_count mid-picture SHALL be ignored.

Reset
REQ-035 While rst=1 the block SHALL enter IDLE on the next edge from any state, including mid-PAYLOAD.
REQ-036 During reset, frame_start, count_for_bram, count_for_bram_b, count_for_bram_en, data_user, byte_valid, picture_done and busy SHALL be 0, txid SHALL be 1, and segment_num SHALL be 0.
REQ-037 Reset SHALL clear the byte_valid delay line.

Structure
REQ-038 FSM state encoding, MEM_LATENCY and the default PAYLOAD_LEN and GAP_CYCLES SHALL reside in shared package tx_pkg.
REQ-039 The byte_valid delay SHALL be sub-module tx_delay_line (parameter DEPTH, synchronous reset).

Verification
REQ-040 redundancy=2, segment_count=3, mac_ready=1 -> 6 frame_start pulses in the (txid,segment_num) order (1,0),(2,0),(1,1),(2,1),(1,2),(2,2); then picture_done, then IDLE.
REQ-041 Single transmission -> data_user high for exactly 1080 cycles; count_for_bram 0..1079; byte_valid rises 3 cycles after data_user.
REQ-042 redundancy=0, segment_count=0 -> exactly one transmission (txid=1, segment_num=0), then picture_done.
REQ-043 segment_count=200 -> last segment_num=149.
REQ-044 mac_ready=0 held for 50 cycles during GAP -> no frame_start until mac_ready=1; txid advances exactly once.
REQ-045 rst at payload byte 500 -> next cycle IDLE with all outputs at reset values; restart produces txid=1, segment_num=0.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and defaults for the segment transmit sequencer.
// Picture config is clamped once at picture start and held in cfg.
package tx_pkg;
  localparam int DEF_SEGMENT_NUMBER_MAX = 150;
  localparam int DEF_PAYLOAD_LEN        = 1080;
  localparam int DEF_GAP_CYCLES         = 12;
  localparam int DEF_MEM_LATENCY        = 3;

  localparam int TXID_W = 8;
  localparam int SEG_W  = 16;
  localparam int IDX_W  = 13;
  localparam int GAP_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [TXID_W-1:0] red;
    logic [SEG_W-1:0]  seg;
  } pic_cfg_t;

  // Zero requests still send one transmission of one segment.
  function automatic pic_cfg_t clamp_cfg(input logic [TXID_W-1:0] red,
                                         input logic [SEG_W-1:0]  cnt,
                                         input logic [SEG_W-1:0]  seg_max);
    pic_cfg_t c;
    c.red = (red == '0) ? TXID_W'(1) : red;
    c.seg = (cnt == '0) ? SEG_W'(1) : cnt;
    if (c.seg > seg_max) c.seg = seg_max;
    return c;
  endfunction
endpackage

// File: rtl/tx_segment_sequencer_if.sv
// Control and payload-indexing signals between picture source, sequencer and frame builder.
// master = the sequencer, slave = whoever consumes its frame/payload timing.
interface tx_segment_sequencer_if;
  import tx_pkg::*;

  logic              enable;
  logic [TXID_W-1:0] redundancy;
  logic [SEG_W-1:0]  segment_count;
  logic              mac_ready;

  logic              frame_start;
  logic [TXID_W-1:0] txid;
  logic [SEG_W-1:0]  segment_num;
  logic [IDX_W-1:0]  count_for_bram;
  logic [IDX_W-1:0]  count_for_bram_b;
  logic              count_for_bram_en;
  logic              data_user;
  logic              byte_valid;
  logic              picture_done;
  logic              busy;

  modport master (
    input  enable, redundancy, segment_count, mac_ready,
    output frame_start, txid, segment_num, count_for_bram, count_for_bram_b,
           count_for_bram_en, data_user, byte_valid, picture_done, busy
  );

  modport slave (
    output enable, redundancy, segment_count, mac_ready,
    input  frame_start, txid, segment_num, count_for_bram, count_for_bram_b,
           count_for_bram_en, data_user, byte_valid, picture_done, busy
  );
endinterface

// File: rtl/tx_delay_line.sv
// Single-bit delay of DEPTH cycles, cleared by synchronous reset.
module tx_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk125MHz,
  input  logic rst,
  input  logic din,
  output logic dout
);
  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH:1] vld_pipe;

    always_ff @(posedge clk125MHz) begin
      if (rst) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[1] <= din;
        for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
    end

    assign dout = vld_pipe[DEPTH];
  end
endmodule

// File: rtl/tx_segment_sequencer.sv
// Walks every segment of a picture redundancy times: START pulse, PAYLOAD byte index
// sweep, then an inter-frame GAP that also waits for the frame builder to be ready.
module tx_segment_sequencer
  import tx_pkg::*;
#(
  parameter int SEGMENT_NUMBER_MAX = DEF_SEGMENT_NUMBER_MAX,
  parameter int PAYLOAD_LEN        = DEF_PAYLOAD_LEN,
  parameter int GAP_CYCLES         = DEF_GAP_CYCLES,
  parameter int MEM_LATENCY        = DEF_MEM_LATENCY
) (
  input logic                    clk125MHz,
  input logic                    rst,
  tx_segment_sequencer_if.master bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SEG_W-1:0] SEG_MAX  = SEG_W'(SEGMENT_NUMBER_MAX);

  tx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TXID_W-1:0] txid_q, txid_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  pic_cfg_t          cfg_q, cfg_d;
  logic              done_q, done_d;

  logic last_tx, last_seg, gap_done;
  logic data_user;

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      txid_q  <= TXID_W'(1);
      seg_q   <= '0;
      cfg_q   <= '{red: TXID_W'(1), seg: SEG_W'(1)};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      txid_q  <= txid_d;
      seg_q   <= seg_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    txid_d   = txid_q;
    seg_d    = seg_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    last_tx  = (txid_q >= cfg_q.red);
    last_seg = (seg_q >= cfg_q.seg - SEG_W'(1));
    gap_done = (gap_q >= LAST_GAP);

    unique case (state_q)
      IDLE: begin
        if (bus.enable && bus.mac_ready) begin
          state_d = START;
          cfg_d   = clamp_cfg(bus.redundancy, bus.segment_count, SEG_MAX);
          txid_d  = TXID_W'(1);
          seg_d   = '0;
        end
      end
      START: begin
        state_d = PAYLOAD;
        idx_d   = '0;
      end
      PAYLOAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = GAP;
          idx_d   = '0;
          gap_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      GAP: begin
        // Gap counter saturates so a long mac_ready stall cannot wrap it.
        if (!gap_done) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (!bus.enable) begin
          state_d = IDLE;
        end else if (last_tx && last_seg) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.mac_ready) begin
          state_d = START;
          if (!last_tx) begin
            txid_d = txid_q + TXID_W'(1);
          end else begin
            txid_d = TXID_W'(1);
            seg_d  = seg_q + SEG_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_user = (state_q == PAYLOAD);

  tx_delay_line #(.DEPTH(MEM_LATENCY)) u_bv_dly (
    .clk125MHz (clk125MHz),
    .rst       (rst),
    .din       (data_user),
    .dout      (bus.byte_valid)
  );

  assign bus.frame_start       = (state_q == START);
  assign bus.txid              = txid_q;
  assign bus.segment_num       = seg_q;
  assign bus.count_for_bram    = idx_q;
  assign bus.count_for_bram_b  = idx_q;
  assign bus.count_for_bram_en = data_user;
  assign bus.data_user         = data_user;
  assign bus.picture_done      = done_q;
  assign bus.busy              = (state_q != IDLE);
endmodule
